// File: rtl/fx_chorus_pkg.sv
// Shared types and constants for the chorus delay-line sequencer and its LFO.
// Imported by fx_chorus_ctrl and chorus_lfo.
package fx_chorus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_L = 3'd1,
        WR_R = 3'd2,
        RD_L = 3'd3,
        RD_R = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int BASE_DLY_DEF = 16;
    localparam int TRI_W        = 8;
    localparam int DEPTH_SHIFT  = 4;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    // States that own the memory port and therefore drive mem_req.
    function automatic logic is_mem_state(input state_t s);
        logic r;
        case (s)
            WR_L, WR_R, RD_L, RD_R: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chorus_lfo.sv
// Triangle LFO for the chorus: phase accumulator plus per-channel tap delays.
// The right channel runs half a period behind the left for stereo spread.
module chorus_lfo
    import fx_chorus_pkg::*;
#(
    parameter int PARAM_W  = 7,
    parameter int ADDR_W   = 11,
    parameter int PHASE_W  = 16,
    parameter int BASE_DLY = BASE_DLY_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               advance,
    input  logic [PARAM_W-1:0] rate,
    input  logic [PARAM_W-1:0] depth,
    output logic [ADDR_W-1:0]  dly_l,
    output logic [ADDR_W-1:0]  dly_r
);

    localparam int PROD_W = TRI_W + PARAM_W;

    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phase_rr_s;
    logic [PROD_W-1:0]  prod_l_s;
    logic [PROD_W-1:0]  prod_r_s;
    logic [PROD_W-1:0]  scaled_l_s;
    logic [PROD_W-1:0]  scaled_r_s;

    // Fold the phase into a triangle and keep its top TRI_W bits.
    function automatic logic [TRI_W-1:0] tri8(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-2:0] t;
        if (p[PHASE_W-1]) begin
            t = ~p[PHASE_W-2:0];
        end else begin
            t = p[PHASE_W-2:0];
        end
        return t[PHASE_W-2 -: TRI_W];
    endfunction

    // Unsigned triangle * depth products, scaled down to sample units.
    always_comb begin
        phase_rr_s = phase_r ^ {1'b1, {(PHASE_W-1){1'b0}}};
        prod_l_s   = {{PARAM_W{1'b0}}, tri8(phase_r)} * {{TRI_W{1'b0}}, depth};
        prod_r_s   = {{PARAM_W{1'b0}}, tri8(phase_rr_s)} * {{TRI_W{1'b0}}, depth};
        scaled_l_s = prod_l_s >> DEPTH_SHIFT;
        scaled_r_s = prod_r_s >> DEPTH_SHIFT;
    end

    // Phase advances once per completed frame by the frame's latched rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= '0;
        end else if (advance) begin
            phase_r <= phase_r + {{(PHASE_W-PARAM_W){1'b0}}, rate};
        end
    end

    // Delays are registered so read addresses come from a stable value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_l <= '0;
            dly_r <= '0;
        end else begin
            dly_l <= ADDR_W'(BASE_DLY) + ADDR_W'(scaled_l_s);
            dly_r <= ADDR_W'(BASE_DLY) + ADDR_W'(scaled_r_s);
        end
    end

endmodule

// File: rtl/fx_chorus_ctrl.sv
// Chorus delay-line sequencer: per sample, write L/R at wr_ptr, then fetch the
// LFO-modulated taps over a req/ack port and present them with a valid strobe.
module fx_chorus_ctrl
    import fx_chorus_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PARAM_W  = 7,
    parameter int ADDR_W   = 11,
    parameter int PHASE_W  = 16,
    parameter int BASE_DLY = BASE_DLY_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_en,
    input  logic [1:0][DATA_W-1:0] audio_in,
    input  logic [PARAM_W-1:0]     fx_rate,
    input  logic [PARAM_W-1:0]     fx_depth,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   mem_ch,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [1:0][DATA_W-1:0] tap_out,
    output logic                   tap_valid,
    output logic                   busy,
    output logic                   overrun
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic                start_s;
    logic                xfer_s;
    logic                adv_s;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [DATA_W-1:0]   aud_l_r;
    logic [DATA_W-1:0]   aud_r_r;
    logic [PARAM_W-1:0]  rate_r;
    logic [PARAM_W-1:0]  depth_r;
    logic [DATA_W-1:0]   rd_l_r;
    logic [ADDR_W-1:0]   dly_l_s;
    logic [ADDR_W-1:0]   dly_r_s;
    logic                req_we_s;
    logic                req_ch_s;
    logic [ADDR_W-1:0]   req_addr_s;
    logic [DATA_W-1:0]   req_wdata_s;

    assign xfer_s = mem_req & mem_ack;
    assign adv_s  = (state_r == DONE);

    chorus_lfo #(
        .PARAM_W  (PARAM_W),
        .ADDR_W   (ADDR_W),
        .PHASE_W  (PHASE_W),
        .BASE_DLY (BASE_DLY)
    ) u_lfo (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (adv_s),
        .rate    (rate_r),
        .depth   (depth_r),
        .dly_l   (dly_l_s),
        .dly_r   (dly_r_s)
    );

    // Next-state logic: memory states advance only on a completed transfer.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (sample_en) begin
                    state_nxt_s = WR_L;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_L: state_nxt_s = xfer_s ? WR_R : WR_L;
            WR_R: state_nxt_s = xfer_s ? RD_L : WR_R;
            RD_L: state_nxt_s = xfer_s ? RD_R : RD_L;
            RD_R: state_nxt_s = xfer_s ? DONE : RD_R;
            DONE: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request fields for the state being entered; WR_L bypasses the latch.
    always_comb begin
        req_we_s    = 1'b0;
        req_ch_s    = CH_L;
        req_addr_s  = '0;
        req_wdata_s = '0;
        case (state_nxt_s)
            WR_L: begin
                req_we_s    = 1'b1;
                req_ch_s    = CH_L;
                req_addr_s  = wr_ptr_r;
                req_wdata_s = start_s ? audio_in[CH_L] : aud_l_r;
            end
            WR_R: begin
                req_we_s    = 1'b1;
                req_ch_s    = CH_R;
                req_addr_s  = wr_ptr_r;
                req_wdata_s = aud_r_r;
            end
            RD_L: begin
                req_ch_s   = CH_L;
                req_addr_s = wr_ptr_r - dly_l_s;
            end
            RD_R: begin
                req_ch_s   = CH_R;
                req_addr_s = wr_ptr_r - dly_r_s;
            end
            default: begin
                req_we_s = 1'b0;
            end
        endcase
    end

    // State register and frame-level bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            wr_ptr_r <= '0;
            aud_l_r  <= '0;
            aud_r_r  <= '0;
            rate_r   <= '0;
            depth_r  <= '0;
            rd_l_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                aud_l_r <= audio_in[CH_L];
                aud_r_r <= audio_in[CH_R];
                rate_r  <= fx_rate;
                depth_r <= fx_depth;
            end
            if (state_r == RD_L && xfer_s) begin
                rd_l_r <= mem_rdata;
            end
            if (state_r == DONE) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
        end
    end

    // Memory port: fields load only on a state change, so they hold until ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_ch    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= is_mem_state(state_nxt_s);
            if (state_nxt_s != state_r && is_mem_state(state_nxt_s)) begin
                mem_we    <= req_we_s;
                mem_ch    <= req_ch_s;
                mem_addr  <= req_addr_s;
                mem_wdata <= req_wdata_s;
            end
        end
    end

    // Tap output, valid strobe and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_out   <= '0;
            tap_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state_r == RD_R && xfer_s) begin
                tap_out <= {mem_rdata, rd_l_r};
            end
            tap_valid <= (state_nxt_s == DONE);
            busy      <= (state_nxt_s != IDLE);
            overrun   <= overrun | (sample_en & (state_r != IDLE));
        end
    end

endmodule

// File: tb/tb_fx_chorus_ctrl.sv
// Bench for fx_chorus_ctrl: frame-level model with a delay-line memory responder,
// per-cycle checks of the memory port, taps and flags, plus literal spot checks.
module tb_fx_chorus_ctrl;

    localparam int DW = 16;
    localparam int PW = 7;
    localparam int AW = 11;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_en = 1'b0;
    logic [1:0][DW-1:0] audio_in = '0;
    logic [PW-1:0]      fx_rate = '0;
    logic [PW-1:0]      fx_depth = '0;
    logic               mem_req, mem_we, mem_ch;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_ack = 1'b0;
    logic [DW-1:0]      mem_rdata = '0;
    logic [1:0][DW-1:0] tap_out;
    logic               tap_valid, busy, overrun;

    fx_chorus_ctrl dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .audio_in(audio_in),
        .fx_rate(fx_rate), .fx_depth(fx_depth), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ch(mem_ch), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .tap_out(tap_out), .tap_valid(tap_valid), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; bit ch; int addr; int data; } txn_t;
    typedef struct { int l; int r; int cyc; } tap_t;

    txn_t txq[$];
    tap_t tapq[$];
    int   mem_l[2048];
    int   mem_r[2048];
    int   errors = 0, checks = 0, cyc = 0, waits = 0, wcnt = 0;
    int   m_wr = 0, m_phase = 0;
    bit   m_overrun = 1'b0;
    logic [31:0] exp_tap = '0;
    logic [28:0] cap = '0;
    int   last_rd[2];
    int   last_wr = -1, last_tap_cyc = 0, start_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Tap delay from the LFO rules in plain arithmetic.
    function automatic int m_dly(input int p, input int depth);
        int t;
        t = (p < 32768) ? p : 65535 - p;
        return 16 + ((t / 128) * depth) / 16;
    endfunction

    task automatic push_frame(input int l, input int r, input int rate, input int depth);
        int al, ar;
        txn_t t;
        tap_t tp;
        al = (m_wr - m_dly(m_phase, depth) + 2048) % 2048;
        ar = (m_wr - m_dly((m_phase + 32768) % 65536, depth) + 2048) % 2048;
        t = '{1'b1, 1'b0, m_wr, l}; txq.push_back(t);
        t = '{1'b1, 1'b1, m_wr, r}; txq.push_back(t);
        t = '{1'b0, 1'b0, al, 0};   txq.push_back(t);
        t = '{1'b0, 1'b1, ar, 0};   txq.push_back(t);
        tp = '{mem_l[al], mem_r[ar], cyc + 4 + 4 * waits};
        tapq.push_back(tp);
        m_wr    = (m_wr + 1) % 2048;
        m_phase = (m_phase + rate) % 65536;
    endtask

    always @(posedge clk) cyc++;

    // Memory responder and per-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack = 1'b0; wcnt = 0;
            txq.delete(); tapq.delete();
            m_wr = 0; m_phase = 0; m_overrun = 1'b0; exp_tap = '0;
            chk("rst_memport", {mem_req, mem_we, mem_ch, mem_addr, mem_wdata}, 0);
            chk("rst_tapside", {tap_out, tap_valid, busy, overrun}, 0);
        end else begin
            if (mem_ack) begin
                txn_t t;
                t = txq.pop_front();
                if (t.we) begin
                    last_wr = t.addr;
                    if (t.ch) mem_r[t.addr] = t.data; else mem_l[t.addr] = t.data;
                end else begin
                    last_rd[t.ch] = t.addr;
                end
                mem_ack = 1'b0;
                wcnt = 0;
            end
            chk("busy", busy, (txq.size() != 0 || tapq.size() != 0));
            chk("overrun", overrun, m_overrun);
            if (tap_valid) begin
                if (tapq.size() == 0) begin
                    fail_now("spurious_tap_valid");
                end else begin
                    tap_t tp;
                    tp = tapq.pop_front();
                    exp_tap = {tp.r[15:0], tp.l[15:0]};
                    last_tap_cyc = cyc;
                    chk("tap_latency", cyc, tp.cyc);
                end
            end
            chk("tap_out", {tap_out[1], tap_out[0]}, exp_tap);
            if (mem_req) begin
                if (txq.size() == 0) begin
                    fail_now("spurious_mem_req");
                end else begin
                    txn_t h;
                    h = txq[0];
                    if (wcnt == 0) begin
                        chk("mem_we", mem_we, h.we);
                        chk("mem_ch", mem_ch, h.ch);
                        chk("mem_addr", mem_addr, h.addr);
                        if (h.we) chk("mem_wdata", mem_wdata, h.data);
                        cap = {mem_we, mem_ch, mem_addr, mem_wdata};
                    end else begin
                        chk("hold_stable", {mem_we, mem_ch, mem_addr, mem_wdata}, cap);
                    end
                    if (wcnt >= waits) begin
                        mem_ack = 1'b1;
                        mem_rdata = h.ch ? mem_r[h.addr][15:0] : mem_l[h.addr][15:0];
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic frame(input int l, input int r, input int rate, input int depth);
        @(negedge clk);
        audio_in[0] = l[15:0];
        audio_in[1] = r[15:0];
        fx_rate  = rate[6:0];
        fx_depth = depth[6:0];
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        start_cyc = cyc;
        push_frame(l, r, rate, depth);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (txq.size() == 0 && tapq.size() == 0) return;
        end
        fail_now("timeout_waiting_for_frame");
    endtask

    task automatic wait_access(input bit ch, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && !mem_we && mem_ch == ch) begin
                found = 1'b1;
                return;
            end
        end
        fail_now("timeout_waiting_for_read");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        // Reset and idle.
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_req", mem_req, 0);
        end

        // Basic frame, zero wait, fixed delay.
        mem_l[2032] = 32'h1111;
        mem_r[2032] = 32'h2222;
        waits = 0;
        frame(32'h1234, 32'hABCD, 0, 0);
        wait_idle();
        chk("t2_rd_l_addr", last_rd[0], 2032);
        chk("t2_rd_r_addr", last_rd[1], 2032);
        chk("t2_tap", {tap_out[1], tap_out[0]}, 32'h2222_1111);
        chk("t2_latency", last_tap_cyc - start_cyc, 4);

        // Three wait states per access.
        waits = 3;
        frame(32'h0F0F, 32'hF0F0, 0, 0);
        wait_idle();
        chk("t3_latency", last_tap_cyc - start_cyc, 16);
        chk("t3_wr_addr", last_wr, 1);

        // Overlapping sample during RD_L.
        waits = 0;
        frame(32'h0101, 32'h0202, 0, 5);
        wait_access(1'b0, found);
        if (found) begin
            audio_in[0] = 16'hDEAD;
            sample_en = 1'b1;
            @(posedge clk);
            #1;
            sample_en = 1'b0;
            m_overrun = 1'b1;
        end
        wait_idle();
        frame(32'h0303, 32'h0404, 0, 5);
        wait_idle();
        chk("t4_wr_addr", last_wr, 3);
        chk("t4_overrun_sticky", overrun, 1);

        // Reset in the middle of RD_R.
        waits = 3;
        frame(32'h0505, 32'h0606, 0, 9);
        wait_access(1'b1, found);
        reset_n = 1'b0;
        #1;
        chk("t6_req_drop", mem_req, 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_tap_valid", tap_valid, 0);
        chk("t6_busy", busy, 0);

        // First frame after reset pins the spread delays at phase 0.
        waits = 0;
        frame(32'h5555, 32'h6666, 0, 127);
        wait_idle();
        chk("t6_wr_addr", last_wr, 0);
        chk("t6_rd_l_addr", last_rd[0], 2032);
        chk("t6_rd_r_addr", last_rd[1], 8);

        // LFO sweep long enough to wrap wr_ptr and phase.
        for (int f = 0; f < 2100; f++) begin
            frame(f * 3 + 7, f * 5 + 11, 127, 127);
            wait_idle();
        end
        chk("sweep_wr_wrap", last_wr, 52);
        chk("end_queues_empty", txq.size() + tapq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
